// File: rtl/timer_irq_service_master.sv
// timer_irq_service_master: Avalon-MM master that programs the interval timer
// and, on every timer IRQ, clears it, fetches the next buffered sample and
// writes that sample to the DAC register.
// Latency: irq sampled at edge N -> ack write N+1, buffer read N+2, DAC write N+3.
// Backpressure: every avm_waitrequest cycle holds the current request and adds one cycle.
//
// Ports:
//   clk, reset        - system clock, synchronous active-high reset
//   enable            - level run request; dropping it finishes the current sequence first
//   irq               - timer interrupt level, held until acknowledged
//   avm_*             - Avalon-MM master (registered address/strobes/writedata)
//   busy              - high in CFG_WR, ACK_WR, RD_SAMPLE, WR_DAC
//   sample_index      - next buffer word to fetch (survives disable, cleared by reset)
//   serviced_count    - completed service sequences, wraps
module timer_irq_service_master #(
  parameter logic [31:0] TIMER_BASE = 32'h0000_0000,
  parameter logic [31:0] BUF_BASE   = 32'h0000_1000,
  parameter logic [31:0] DAC_BASE   = 32'h0000_2000,
  parameter int          BUF_LEN    = 64,
  parameter logic [31:0] PERIOD     = 32'd1134,
  localparam int         IDX_W      = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             irq,
  output logic [31:0]      avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest,
  output logic             busy,
  output logic [IDX_W-1:0] sample_index,
  output logic [31:0]      serviced_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_WR,
    S_WAIT_IRQ,
    S_ACK_WR,
    S_RD_SAMPLE,
    S_WR_DAC
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BUF_LEN - 1);

  state_t           r_state;
  logic [31:0]      r_address;
  logic             r_read;
  logic             r_write;
  logic [31:0]      r_writedata;
  logic [IDX_W-1:0] r_index;
  logic [31:0]      r_count;
  logic [31:0]      r_sample;

  state_t           w_state_nxt;
  logic [31:0]      w_address_nxt;
  logic             w_read_nxt;
  logic             w_write_nxt;
  logic [31:0]      w_writedata_nxt;
  logic [IDX_W-1:0] w_index_nxt;
  logic [31:0]      w_count_nxt;
  logic [31:0]      w_sample_nxt;
  logic             w_done;
  logic [31:0]      w_buf_addr;

  // A transfer completes on the edge where its strobe is up and the slave does not stall.
  assign w_done     = (r_read | r_write) & ~avm_waitrequest;
  assign w_buf_addr = BUF_BASE + {{(30-IDX_W){1'b0}}, r_index, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_address   <= 32'd0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_writedata <= 32'd0;
      r_index     <= '0;
      r_count     <= 32'd0;
      r_sample    <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_address   <= w_address_nxt;
      r_read      <= w_read_nxt;
      r_write     <= w_write_nxt;
      r_writedata <= w_writedata_nxt;
      r_index     <= w_index_nxt;
      r_count     <= w_count_nxt;
      r_sample    <= w_sample_nxt;
    end
  end

  // Next-state logic also computes the next registered bus outputs, so each
  // request is launched on the same edge that enters its state and is held
  // untouched until that state sees completion.
  always_comb begin
    w_state_nxt     = r_state;
    w_address_nxt   = r_address;
    w_read_nxt      = r_read;
    w_write_nxt     = r_write;
    w_writedata_nxt = r_writedata;
    w_index_nxt     = r_index;
    w_count_nxt     = r_count;
    w_sample_nxt    = r_sample;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt     = S_CFG_WR;
          w_write_nxt     = 1'b1;
          w_address_nxt   = TIMER_BASE;
          w_writedata_nxt = PERIOD;
        end
      end
      S_CFG_WR: begin
        if (w_done) begin
          w_state_nxt = S_WAIT_IRQ;
          w_write_nxt = 1'b0;
        end
      end
      S_WAIT_IRQ: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (irq) begin
          w_state_nxt     = S_ACK_WR;
          w_write_nxt     = 1'b1;
          w_address_nxt   = TIMER_BASE + 32'd4;
          w_writedata_nxt = 32'd0;
        end
      end
      S_ACK_WR: begin
        if (w_done) begin
          w_state_nxt   = S_RD_SAMPLE;
          w_write_nxt   = 1'b0;
          w_read_nxt    = 1'b1;
          w_address_nxt = w_buf_addr;
        end
      end
      S_RD_SAMPLE: begin
        if (w_done) begin
          w_state_nxt     = S_WR_DAC;
          w_read_nxt      = 1'b0;
          w_write_nxt     = 1'b1;
          w_address_nxt   = DAC_BASE;
          w_sample_nxt    = avm_readdata;
          w_writedata_nxt = avm_readdata;
        end
      end
      S_WR_DAC: begin
        if (w_done) begin
          w_state_nxt = S_WAIT_IRQ;
          w_write_nxt = 1'b0;
          w_index_nxt = (r_index == IDX_LAST) ? '0 : r_index + 1'b1;
          w_count_nxt = r_count + 32'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
      end
    endcase
  end

  assign avm_address    = r_address;
  assign avm_read       = r_read;
  assign avm_write      = r_write;
  assign avm_writedata  = r_writedata;
  assign busy           = (r_state != S_IDLE) && (r_state != S_WAIT_IRQ);
  assign sample_index   = r_index;
  assign serviced_count = r_count;

endmodule
